// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch-stage program-counter controller.
//
// Drives pcsel / pc_en / targaddr into the PC register and handshakes with
// instruction memory. A control-flow redirect that arrives while a fetch is
// still in flight is parked in pending registers until imem_ready, and
// wrong-path fetches are flushed. halt_req stops fetching until reset.
//
// Optional feature macro: BRANCH_STATS_EN (saturating redirect counter on
// taken_cnt; tied to zero when undefined).
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   stall_i      hazard stall, hold PC
//   br_valid     control-flow instruction resolved this cycle
//   br_kind      00 cond branch, 01 JALR, 11 JAL
//   br_taken     cond-branch outcome
//   br_target    offset (branch/JAL) or absolute address (JALR)
//   halt_req     stop fetching
//   imem_ready   imem returns the word at the current PC
//   imem_req     fetch request
//   pc_en        PC loads next value on this edge
//   pcsel        00 +1, 10 branch, 01 JALR, 11 JAL
//   targaddr     redirect target, valid while pc_en=1
//   fetch_valid  returned word is on-path
//   flush        kill younger instructions, one cycle per redirect
//   halted       sequencer halted
//   taken_cnt    redirects applied (stats build only)
module pc_sequencer #(
  parameter int unsigned n    = 32,
  parameter int unsigned CNTW = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            br_valid,
  input  logic [1:0]      br_kind,
  input  logic            br_taken,
  input  logic [n-1:0]    br_target,
  input  logic            halt_req,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic            pc_en,
  output logic [1:0]      pcsel,
  output logic [n-1:0]    targaddr,
  output logic            fetch_valid,
  output logic            flush,
  output logic            halted,
  output logic [CNTW-1:0] taken_cnt
);

  typedef enum logic [1:0] {RUN, REDIR, HALT} state_t;

  state_t       state, state_nxt;
  logic [1:0]   pend_sel;
  logic [n-1:0] pend_targ;
  logic         pend_ld;
  logic         redirect;
  logic [1:0]   redir_sel;

  assign redirect = br_valid & (br_taken | (br_kind != 2'b00));

  always_comb begin
    unique case (br_kind)
      2'b00:   redir_sel = 2'b10;
      2'b01:   redir_sel = 2'b01;
      default: redir_sel = 2'b11;
    endcase
  end

  // Outputs are held at zero while reset is asserted, so they are gated by
  // reset here rather than depending only on the (already reset) state.
  always_comb begin
    state_nxt   = state;
    pend_ld     = 1'b0;
    imem_req    = 1'b0;
    pc_en       = 1'b0;
    pcsel       = 2'b00;
    targaddr    = '0;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    halted      = 1'b0;
    if (reset) begin
      unique case (state)
        RUN: begin
          imem_req = 1'b1;
          if (halt_req) begin
            flush     = 1'b1;
            state_nxt = HALT;
          end else if (redirect) begin
            flush = 1'b1;
            if (imem_ready) begin
              pc_en    = 1'b1;
              pcsel    = redir_sel;
              targaddr = br_target;
            end else begin
              pend_ld   = 1'b1;
              state_nxt = REDIR;
            end
          end else if (!stall_i) begin
            pc_en       = imem_ready;
            fetch_valid = imem_ready;
          end
        end
        REDIR: begin
          imem_req = 1'b1;
          if (halt_req) begin
            state_nxt = HALT;
          end else if (imem_ready) begin
            pc_en     = 1'b1;
            pcsel     = pend_sel;
            targaddr  = pend_targ;
            state_nxt = RUN;
          end
        end
        HALT: begin
          halted = 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      pend_sel  <= '0;
      pend_targ <= '0;
    end else begin
      state <= state_nxt;
      if (pend_ld) begin
        pend_sel  <= redir_sel;
        pend_targ <= br_target;
      end
    end
  end

  // The front end was already flushed when REDIR was entered, so no younger
  // control-flow instruction can legitimately resolve here.
  always_ff @(posedge clock) begin
    if (reset && state == REDIR)
      assert (!br_valid) else $error("pc_sequencer: br_valid asserted while redirect pending");
  end

`ifdef BRANCH_STATS_EN
  logic [CNTW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (pc_en && pcsel != 2'b00 && cnt != '1)
      cnt <= cnt + 1'b1;
  end

  assign taken_cnt = cnt;
`else
  assign taken_cnt = '0;
`endif

endmodule
